readback_buffer_dual_clk: RTL and testbench

//  Carries result words (counter/ADC readback) from the subclk domain back into the clk (host) domain.

---
 rtl/ioncontrol_cdc_pkg.sv | 9 +
 rtl/cdc_sync_bit.sv | 26 ++
 rtl/readback_buffer_dual_clk.sv | 131 +++++++++++++
 tb/tb_readback_buffer_dual_clk.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioncontrol_cdc_pkg.sv
// Shared constants for the ioncontrol clock-domain-crossing blocks.
//   SYNC_STAGES_DEFAULT : flops per single-bit synchroniser (minimum 2)
//   DEFAULT_DATA_WIDTH  : default readback word width
package ioncontrol_cdc_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEFAULT_DATA_WIDTH  = 24;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser into the domain of clk.
// Ports:
//   clk : destination clock
//   d   : asynchronous input bit
//   q   : synchronised output (STAGES clk edges of latency)
// STAGES below 2 is raised to 2; one flop is never enough for a crossing.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync;

    // Shift the asynchronous bit through the synchroniser chain.
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[N-2:0], d};
    end

    assign q = r_sync[N-1];

endmodule

// File: rtl/readback_buffer_dual_clk.sv
// Carries result words from the subclk domain into the clk (host) domain
// with a toggle req/ack handshake. The data word (hold/hold_lost) crosses as
// a quasi-static bus that is stable for as long as sub_busy is high; only the
// single-bit toggles and the reset go through synchronisers.
// Ports (subclk domain): subclk, sub_valid, sub_data, sub_busy
// Ports (clk domain):    clk, reset, rd, clr_overrun, q, q_lost, avail, overrun
// All outputs come straight from flops in their own domain.
// reset must be held long enough for the subclk side to clear req_tgl and for
// that to settle back through the clk-side synchroniser; while reset is high
// the edge detector keeps tracking so no stale toggle is seen afterwards.
module readback_buffer_dual_clk
    import ioncontrol_cdc_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             subclk,
    input  logic             sub_valid,
    input  logic [WIDTH-1:0] sub_data,
    output logic             sub_busy,
    input  logic             rd,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] q,
    output logic             q_lost,
    output logic             avail,
    output logic             overrun
);

    // subclk domain state
    logic             w_reset_sub;
    logic             w_ack_sync;
    logic             r_req_tgl;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_lost;
    logic             r_lost_pend;
    logic             r_sub_busy;

    // clk domain state
    logic             w_req_sync;
    logic             w_deliver;
    logic             r_req_seen;
    logic             r_ack_tgl;
    logic [WIDTH-1:0] r_q;
    logic             r_q_lost;
    logic             r_avail;
    logic             r_overrun;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_reset (
        .clk (subclk),
        .d   (reset),
        .q   (w_reset_sub)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (subclk),
        .d   (r_ack_tgl),
        .q   (w_ack_sync)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk (clk),
        .d   (r_req_tgl),
        .q   (w_req_sync)
    );

    // Source side: capture an offered word when idle, otherwise note the drop.
    always_ff @(posedge subclk) begin
        if (w_reset_sub) begin
            r_req_tgl   <= 1'b0;
            r_hold      <= {WIDTH{1'b0}};
            r_hold_lost <= 1'b0;
            r_lost_pend <= 1'b0;
            r_sub_busy  <= 1'b0;
        end else if (sub_valid && !r_sub_busy) begin
            r_hold      <= sub_data;
            r_hold_lost <= r_lost_pend;
            r_lost_pend <= 1'b0;
            r_req_tgl   <= ~r_req_tgl;
            r_sub_busy  <= 1'b1;
        end else begin
            if (sub_valid) begin
                r_lost_pend <= 1'b1;
            end
            // Busy until the ack toggle has come back round.
            r_sub_busy <= (r_req_tgl != w_ack_sync);
        end
    end

    // Edge-detect flop for the synchronised request toggle; runs through reset.
    always_ff @(posedge clk) begin
        r_req_seen <= w_req_sync;
    end

    assign w_deliver = w_req_sync ^ r_req_seen;

    // Destination side: deliver, acknowledge, read and overrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= {WIDTH{1'b0}};
            r_q_lost  <= 1'b0;
            r_avail   <= 1'b0;
            r_overrun <= 1'b0;
            r_ack_tgl <= 1'b0;
        end else begin
            if (w_deliver) begin
                // hold is stable here: the source stays busy until ack returns.
                r_q       <= r_hold;
                r_q_lost  <= r_hold_lost;
                r_avail   <= 1'b1;
                r_ack_tgl <= w_req_sync;
            end else if (rd) begin
                r_avail <= 1'b0;
            end
            // A new overrun takes priority over a clear on the same edge.
            if (w_deliver && r_avail && !rd) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sub_busy = r_sub_busy;
    assign q        = r_q;
    assign q_lost   = r_q_lost;
    assign avail    = r_avail;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_readback_buffer_dual_clk.sv
`timescale 1ns/1ps
module tb_readback_buffer_dual_clk;

    logic        clk = 1'b0;
    logic        subclk = 1'b0;
    logic        reset = 1'b1;
    logic        sub_valid = 1'b0;
    logic [23:0] sub_data = 24'h000000;
    logic        sub_busy;
    logic        rd = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [23:0] q;
    logic        q_lost;
    logic        avail;
    logic        overrun;

    realtime clk_half = 5.0;
    realtime sub_half = 6.5;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];

    typedef struct {
        logic [23:0] data;
        logic [23:0] exp_q;
        logic        exp_lost;
    } vec_t;

    vec_t vecs[4];

    readback_buffer_dual_clk dut (
        .clk         (clk),
        .reset       (reset),
        .subclk      (subclk),
        .sub_valid   (sub_valid),
        .sub_data    (sub_data),
        .sub_busy    (sub_busy),
        .rd          (rd),
        .clr_overrun (clr_overrun),
        .q           (q),
        .q_lost      (q_lost),
        .avail       (avail),
        .overrun     (overrun)
    );

    initial forever #(clk_half) clk = ~clk;
    initial forever #(sub_half) subclk = ~subclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one word; returns just after the subclk edge that samples it.
    task automatic offer(input logic [23:0] d);
        @(negedge subclk);
        sub_valid = 1'b1;
        sub_data  = d;
        @(posedge subclk);
        #0.1;
        sub_valid = 1'b0;
    endtask

    task automatic wait_avail(input int budget, output int n);
        n = 0;
        while (!avail && n < budget) begin
            @(posedge clk);
            #0.1;
            n++;
        end
    endtask

    task automatic wait_busy_low(input int budget, output int n);
        n = 0;
        while (sub_busy && n < budget) begin
            @(posedge subclk);
            #0.1;
            n++;
        end
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #0.1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #0.1;
        reset = 1'b0;
    endtask

    // Free-running producer/consumer against an in-order queue model.
    task automatic run_phase(input realtime ch, input realtime sh, input int nwords);
        int got;
        clk_half = ch;
        sub_half = sh;
        repeat (20) @(negedge clk);
        got = 0;
        fork
            begin : producer
                int sent;
                int guard;
                sent  = 0;
                guard = 0;
                while (sent < nwords && guard < 40000) begin
                    @(negedge subclk);
                    guard++;
                    if (!sub_busy && $urandom_range(0, 3) != 0) begin
                        sub_data  = 24'($urandom);
                        sub_valid = 1'b1;
                        exp_q.push_back(sub_data);
                        sent++;
                    end else begin
                        sub_valid = 1'b0;
                    end
                end
                @(negedge subclk);
                sub_valid = 1'b0;
            end
            begin : consumer
                int idle;
                logic [23:0] e;
                idle = 0;
                while (got < nwords && idle < 5000) begin
                    @(negedge clk);
                    rd = 1'b0;
                    if (avail) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_spurious_word", 32'(q), 32'hFFFFFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rand_q", 32'(q), 32'(e));
                        end
                        chk("rand_q_lost", 32'(q_lost), 32'd0);
                        rd = 1'b1;
                        got++;
                        idle = 0;
                    end else begin
                        idle++;
                    end
                end
                @(negedge clk);
                rd = 1'b0;
            end
        join
        chk("rand_word_count", 32'(got), 32'(nwords));
        chk("rand_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int spur;

        vecs[0] = '{data: 24'hABCDEF, exp_q: 24'hABCDEF, exp_lost: 1'b0};
        vecs[1] = '{data: 24'h000000, exp_q: 24'h000000, exp_lost: 1'b0};
        vecs[2] = '{data: 24'hFFFFFF, exp_q: 24'hFFFFFF, exp_lost: 1'b0};
        vecs[3] = '{data: 24'h800001, exp_q: 24'h800001, exp_lost: 1'b0};

        // Reset state
        do_reset(30);
        repeat (10) @(negedge clk);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_q_lost", 32'(q_lost), 32'd0);
        chk("reset_avail", 32'(avail), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_sub_busy", 32'(sub_busy), 32'd0);

        // Single words from the table: latency, data, busy release, read
        for (int i = 0; i < 4; i++) begin
            offer(vecs[i].data);
            wait_avail(20, n);
            chk("vec_avail", 32'(avail), 32'd1);
            chk("vec_latency_le4", 32'(n <= 4), 32'd1);
            chk("vec_q", 32'(q), 32'(vecs[i].exp_q));
            chk("vec_q_lost", 32'(q_lost), 32'(vecs[i].exp_lost));
            wait_busy_low(20, m);
            chk("vec_busy_fall_le4", 32'(m <= 4), 32'd1);
            rd_pulse();
            chk("vec_avail_after_rd", 32'(avail), 32'd0);
            chk("vec_overrun", 32'(overrun), 32'd0);
        end

        // rd with avail=0 is ignored
        rd_pulse();
        chk("idle_rd_avail", 32'(avail), 32'd0);

        // Drop: second word offered while busy
        @(negedge subclk);
        sub_valid = 1'b1;
        sub_data  = 24'h000111;
        @(negedge subclk);
        sub_data  = 24'h000222;
        @(negedge subclk);
        sub_valid = 1'b0;
        wait_avail(20, n);
        chk("drop_first_q", 32'(q), 32'h000111);
        chk("drop_first_lost", 32'(q_lost), 32'd0);
        rd_pulse();
        wait_busy_low(20, m);
        offer(24'h000333);
        wait_avail(20, n);
        chk("drop_third_q", 32'(q), 32'h000333);
        chk("drop_third_lost", 32'(q_lost), 32'd1);
        rd_pulse();

        // Overrun: two words without rd
        wait_busy_low(20, m);
        offer(24'h00AAAA);
        wait_avail(20, n);
        wait_busy_low(20, m);
        offer(24'h00BBBB);
        repeat (10) @(negedge clk);
        chk("ovr_q", 32'(q), 32'h00BBBB);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_avail", 32'(avail), 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_avail_kept", 32'(avail), 32'd1);
        rd_pulse();
        chk("ovr_avail_after_rd", 32'(avail), 32'd0);

        // rd on the delivery edge: new word wins, no overrun
        wait_busy_low(20, m);
        offer(24'h0C0C0C);
        wait_avail(20, n);
        wait_busy_low(20, m);
        offer(24'h0D0D0D);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rdedge_pre_q", 32'(q), 32'h0C0C0C);
        rd = 1'b1;
        @(posedge clk);
        #0.1;
        chk("rdedge_q", 32'(q), 32'h0D0D0D);
        chk("rdedge_avail", 32'(avail), 32'd1);
        chk("rdedge_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rd = 1'b0;
        rd_pulse();
        chk("rdedge_avail_after_rd", 32'(avail), 32'd0);

        // Reset between req flip and delivery
        wait_busy_low(20, m);
        offer(24'h777777);
        @(posedge clk);
        #0.1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #0.1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_avail", 32'(avail), 32'd0);
        chk("rst_mid_q", 32'(q), 32'd0);
        wait_busy_low(4, m);
        chk("rst_mid_busy", 32'(sub_busy), 32'd0);
        spur = 0;
        repeat (20) begin
            @(negedge clk);
            if (avail) spur++;
        end
        chk("rst_mid_no_spurious", 32'(spur), 32'd0);
        offer(24'h5A5A5A);
        wait_avail(20, n);
        chk("rst_next_avail", 32'(avail), 32'd1);
        chk("rst_next_q", 32'(q), 32'h5A5A5A);
        chk("rst_next_lost", 32'(q_lost), 32'd0);
        rd_pulse();

        // Randomised traffic at three clock ratios
        run_phase(5.0, 5.0 / 3.0, 334);
        run_phase(5.0, 15.0, 333);
        run_phase(5.0, 5.15, 333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
